// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - Debounced x4 quadrature decoder with step/direction and error count
//
// Ports:
//   clk      - single clock; all state updates on its rising edge
//   reset    - synchronous, active-high reset
//   quad_a   - encoder channel A (asynchronous)
//   quad_b   - encoder channel B (asynchronous)
//   enable   - when low, step is suppressed while direction/state tracking continues
//   clear    - synchronous clear of err_cnt
//   step     - one-cycle pulse per accepted quadrature edge
//   up_down  - direction of the last legal edge (1=up, 0=down), held between steps
//   err      - one-cycle pulse when both channels change on the same edge
//   err_cnt  - saturating count of illegal transitions
//   ready    - high once the start-up settling period has completed
module quad_decoder #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       quad_a,
    input  logic       quad_b,
    input  logic       enable,
    input  logic       clear,
    output logic       step,
    output logic       up_down,
    output logic       err,
    output logic [7:0] err_cnt,
    output logic       ready
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] DB_LAST   = 4'(DB_CYCLES - 1);
    // INIT ends on edge DB_CYCLES+2 after reset; the counter reads DB_CYCLES+1 then.
    localparam logic [4:0] INIT_LAST = 5'(DB_CYCLES + 1);

    state_t     state;
    state_t     state_next;

    logic       sync1_a;
    logic       sync2_a;
    logic       sync1_b;
    logic       sync2_b;
    logic       filt_a;
    logic       filt_b;
    logic [3:0] db_cnt_a;
    logic [3:0] db_cnt_b;
    logic [1:0] prev;
    logic [4:0] init_cnt;

    logic       init_done;
    logic [1:0] cur;
    logic [1:0] changed;
    logic       legal;
    logic       both;
    logic       dir_up;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        init_done  = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_next = RUN;
                    init_done  = 1'b1;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // Transition decode on the filtered pair {A,B} against the previous pair.
    always_comb begin
        cur     = {filt_a, filt_b};
        changed = cur ^ prev;
        legal   = (changed == 2'b01) || (changed == 2'b10);
        both    = (changed == 2'b11);
        case ({prev, cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: dir_up = 1'b1;
            default:                                 dir_up = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_a  <= 1'b0;
            sync2_a  <= 1'b0;
            sync1_b  <= 1'b0;
            sync2_b  <= 1'b0;
            filt_a   <= 1'b0;
            filt_b   <= 1'b0;
            db_cnt_a <= 4'd0;
            db_cnt_b <= 4'd0;
            prev     <= 2'b00;
            init_cnt <= 5'd0;
            step     <= 1'b0;
            err      <= 1'b0;
            up_down  <= 1'b1;
            err_cnt  <= 8'd0;
            ready    <= 1'b0;
        end else begin
            sync1_a <= quad_a;
            sync2_a <= sync1_a;
            sync1_b <= quad_b;
            sync2_b <= sync1_b;

            // A change is accepted only after DB_CYCLES consecutive differing cycles;
            // any cycle that matches the filtered value restarts the count.
            if (sync2_a != filt_a) begin
                if (db_cnt_a == DB_LAST) begin
                    filt_a   <= sync2_a;
                    db_cnt_a <= 4'd0;
                end else begin
                    db_cnt_a <= db_cnt_a + 4'd1;
                end
            end else begin
                db_cnt_a <= 4'd0;
            end

            if (sync2_b != filt_b) begin
                if (db_cnt_b == DB_LAST) begin
                    filt_b   <= sync2_b;
                    db_cnt_b <= 4'd0;
                end else begin
                    db_cnt_b <= db_cnt_b + 4'd1;
                end
            end else begin
                db_cnt_b <= 4'd0;
            end

            step <= 1'b0;
            err  <= 1'b0;

            if (state == INIT) begin
                init_cnt <= init_cnt + 5'd1;
                if (init_done) begin
                    // Seed from the synchronised inputs so start-up never emits a step.
                    filt_a   <= sync2_a;
                    filt_b   <= sync2_b;
                    db_cnt_a <= 4'd0;
                    db_cnt_b <= 4'd0;
                    prev     <= {sync2_a, sync2_b};
                    ready    <= 1'b1;
                end
            end else begin
                prev <= cur;
                if (legal) begin
                    step    <= enable;
                    up_down <= dir_up;
                end
                if (both) begin
                    err <= 1'b1;
                end
            end

            if (clear) begin
                err_cnt <= 8'd0;
            end else if ((state == RUN) && both && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
